// File: rtl/writeptr_full_lvl.sv
// Write-domain pointer and status for an async dual-clock FIFO: binary/Gray write
// pointer, full, fill level, programmable almost-full and sticky overflow.
module writeptr_full_lvl #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                ovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LEVEL);
  localparam logic [ADDRSIZE:0] PTR_ZERO  = {(ADDRSIZE+1){1'b0}};

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b = g;
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic              wfull_r;
  logic              walmost_full_r;
  logic [ADDRSIZE:0] wlevel_r;
  logic              wovf_r;

  logic              inc_s;
  logic [ADDRSIZE:0] wbin_next_s;
  logic [ADDRSIZE:0] wgray_next_s;
  logic [ADDRSIZE:0] full_cmp_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next_s;
  logic              full_next_s;
  logic              afull_next_s;
  logic              ovf_next_s;

  // Next-state pointer and status; full is the Gray pointer one lap ahead of rptr
  always_comb begin
    inc_s        = winc & ~wfull_r;
    wbin_next_s  = wbin_r + {{ADDRSIZE{1'b0}}, inc_s};
    wgray_next_s = bin2gray(wbin_next_s);
    full_cmp_s   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    full_next_s  = (wgray_next_s == full_cmp_s);
    rbin_s       = gray2bin(wq2_rptr);
    level_next_s = wbin_next_s - rbin_s;
    afull_next_s = (level_next_s >= AFULL_THR);
    ovf_next_s   = (winc & wfull_r) | (wovf_r & ~ovf_clr);
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r         <= PTR_ZERO;
      wptr_r         <= PTR_ZERO;
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= PTR_ZERO;
      wovf_r         <= 1'b0;
    end else begin
      wbin_r         <= wbin_next_s;
      wptr_r         <= wgray_next_s;
      wfull_r        <= full_next_s;
      walmost_full_r <= afull_next_s;
      wlevel_r       <= level_next_s;
      wovf_r         <= ovf_next_s;
    end
  end

  assign wen          = winc & ~wfull_r;
  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wptr         = wptr_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign wovf         = wovf_r;

endmodule

// File: tb/tb_writeptr_full_lvl.sv
// Self-checking bench for writeptr_full_lvl: directed scenarios plus random traffic
// against a write/read counting model.
module tb_writeptr_full_lvl;
  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [AS:0]   wq2_rptr;
  logic          ovf_clr;
  logic          wen;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AS:0]   wlevel;
  logic          wovf;

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes and current synchronised read count, as plain integers
  int m_wr, m_rd;
  bit m_full, m_af, m_ovf, m_w, m_clr;

  writeptr_full_lvl #(.ADDRSIZE(AS), .AFULL_LEVEL(AF)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr), .ovf_clr(ovf_clr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [AS:0] to_gray(input int n);
    int v;
    v = n % 32;
    return (AS+1)'(v ^ (v >> 1));
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic set_in(input bit w, input bit clr, input int rd);
    m_w = w; m_clr = clr; m_rd = rd;
    winc = w; ovf_clr = clr; wq2_rptr = to_gray(rd);
    #1;
  endtask

  task automatic tick();
    int lvl;
    bit fb;
    @(posedge wclk);
    fb = m_full;
    if (m_w && !fb) m_wr++;
    lvl = m_wr - m_rd;
    m_full = (lvl == DEPTH);
    m_af = (lvl >= AF);
    m_ovf = (m_w && fb) || (m_ovf && !m_clr);
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    model_reset();
    set_in(1, 0, 0);
    #12;
    checks++; if (wptr !== 5'd0) begin errors++; $display("FAIL reset_wptr got %0d want 0", wptr); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", waddr); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %0b want 0", wfull); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %0b want 0", walmost_full); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel got %0d want 0", wlevel); end
    checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL reset_wovf got %0b want 0", wovf); end
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL reset_release_wen got %0b want 1", wen); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      set_in(1, 0, 0);
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL fill_wen step %0d got %0b want 1", i, wen); end
      checks++; if (waddr !== 4'(i - 1)) begin errors++; $display("FAIL fill_waddr step %0d got %0d want %0d", i, waddr, i - 1); end
      tick();
      checks++; if (wlevel !== 5'(i)) begin errors++; $display("FAIL fill_wlevel step %0d got %0d want %0d", i, wlevel, i); end
      checks++; if (walmost_full !== (i >= AF)) begin errors++; $display("FAIL fill_afull step %0d got %0b want %0b", i, walmost_full, i >= AF); end
      checks++; if (wfull !== (i == DEPTH)) begin errors++; $display("FAIL fill_wfull step %0d got %0b want %0b", i, wfull, i == DEPTH); end
    end
    checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL fill_wptr got %b want 11000", wptr); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 0);
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL ovf_wen cyc %0d got %0b want 0", k, wen); end
      checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL ovf_waddr cyc %0d got %0d want 0", k, waddr); end
      tick();
      checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr cyc %0d got %b want 11000", k, wptr); end
      checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_set cyc %0d got %0b want 1", k, wovf); end
      checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL ovf_wlevel cyc %0d got %0d want 16", k, wlevel); end
    end
    set_in(0, 1, 0);
    tick();
    checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", wovf); end
    set_in(1, 1, 0);
    tick();
    checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b want 1", wovf); end
  endtask

  task automatic test_drain_wrap();
    set_in(0, 0, 4);
    tick();
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL drain_wfull got %0b want 0", wfull); end
    checks++; if (wlevel !== 5'd12) begin errors++; $display("FAIL drain_wlevel got %0d want 12", wlevel); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL drain_afull got %0b want 0", walmost_full); end
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 4);
      checks++; if (waddr !== 4'(i)) begin errors++; $display("FAIL wrap_waddr step %0d got %0d want %0d", i, waddr, i); end
      tick();
    end
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL wrap_wfull got %0b want 1", wfull); end
    checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL wrap_wlevel got %0d want 16", wlevel); end
    checks++; if (wptr !== to_gray(20)) begin errors++; $display("FAIL wrap_wptr got %b want %b", wptr, to_gray(20)); end
  endtask

  task automatic test_simultaneous();
    set_in(0, 0, 7);
    tick();
    checks++; if (wlevel !== 5'd13) begin errors++; $display("FAIL simul_pre_wlevel got %0d want 13", wlevel); end
    set_in(1, 0, 8);
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL simul_wen got %0b want 1", wen); end
    tick();
    checks++; if (wlevel !== 5'd13) begin errors++; $display("FAIL simul_wlevel got %0d want 13", wlevel); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL simul_afull got %0b want 0", walmost_full); end
  endtask

  task automatic test_random();
    int rd, wpct;
    bit w, clr;
    rd = m_rd;
    for (int c = 0; c < 600; c++) begin
      wpct = ((c / 100) % 2 == 0) ? 80 : 30;
      w = ($urandom_range(0, 99) < wpct);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1 && rd < m_wr) rd++;
      set_in(w, clr, rd);
      checks++; if (wen !== (w && !m_full)) begin errors++; $display("FAIL rand_wen cyc %0d got %0b want %0b", c, wen, w && !m_full); end
      checks++; if (waddr !== 4'(m_wr % DEPTH)) begin errors++; $display("FAIL rand_waddr cyc %0d got %0d want %0d", c, waddr, m_wr % DEPTH); end
      tick();
      checks++; if (wptr !== to_gray(m_wr)) begin errors++; $display("FAIL rand_wptr cyc %0d got %b want %b", c, wptr, to_gray(m_wr)); end
      checks++; if (wlevel !== 5'(m_wr - m_rd)) begin errors++; $display("FAIL rand_wlevel cyc %0d got %0d want %0d", c, wlevel, m_wr - m_rd); end
      checks++; if (wfull !== m_full) begin errors++; $display("FAIL rand_wfull cyc %0d got %0b want %0b", c, wfull, m_full); end
      checks++; if (walmost_full !== m_af) begin errors++; $display("FAIL rand_afull cyc %0d got %0b want %0b", c, walmost_full, m_af); end
      checks++; if (wovf !== m_ovf) begin errors++; $display("FAIL rand_wovf cyc %0d got %0b want %0b", c, wovf, m_ovf); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    model_reset();
    set_in(0, 0, 0);
    wrst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_in(1, 0, 0);
      tick();
    end
    checks++; if (wlevel !== 5'd9) begin errors++; $display("FAIL arst_pre_wlevel got %0d want 9", wlevel); end
    set_in(0, 0, 0);
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    checks++; if (wptr !== 5'd0) begin errors++; $display("FAIL arst_wptr got %0d want 0", wptr); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL arst_waddr got %0d want 0", waddr); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL arst_wlevel got %0d want 0", wlevel); end
    checks++; if (wfull !== 1'b0 || walmost_full !== 1'b0 || wovf !== 1'b0) begin errors++; $display("FAIL arst_flags got %0b%0b%0b want 000", wfull, walmost_full, wovf); end
    model_reset();
    wrst_n = 1'b1;
    set_in(1, 0, 0);
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL arst_release_wen got %0b want 1", wen); end
    tick();
    checks++; if (wlevel !== 5'd1) begin errors++; $display("FAIL arst_first_write got %0d want 1", wlevel); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
